// File: rtl/axi_sram_slave.sv
`timescale 1ns/1ps
// AXI4 slave backed by an on-chip byte-addressable SRAM, 64-bit data path.
// Read and write channels are independent FSMs, one outstanding burst each.
// FIXED, INCR and WRAP bursts; malformed address phases complete normally
// but answer SLVERR.
//
// Write FSM
//   state  | meaning
//   W_IDLE | awready high, waiting for an address phase
//   W_DATA | wready high, consuming len+1 beats into the SRAM
//   W_RESP | bvalid high, holding bid/bresp until bready
//
// Read FSM
//   state  | meaning
//   R_IDLE | arready high, waiting for an address phase
//   R_WAIT | RD_WAIT idle cycles before the first beat (down-counter)
//   R_DATA | rvalid high, streaming beats; next word loads on each handshake
module axi_sram_slave #(
    parameter int MEM_LOG2 = 16,
    parameter int RD_WAIT  = 0
) (
    input  logic        clock,
    input  logic        reset,

    input  logic [3:0]  SAXI_awid,
    input  logic [31:0] SAXI_awaddr,
    input  logic [7:0]  SAXI_awlen,
    input  logic [2:0]  SAXI_awsize,
    input  logic [1:0]  SAXI_awburst,
    input  logic        SAXI_awvalid,
    output logic        SAXI_awready,

    input  logic [63:0] SAXI_wdata,
    input  logic [7:0]  SAXI_wstrb,
    input  logic        SAXI_wlast,
    input  logic        SAXI_wvalid,
    output logic        SAXI_wready,

    output logic [3:0]  SAXI_bid,
    output logic [1:0]  SAXI_bresp,
    output logic        SAXI_bvalid,
    input  logic        SAXI_bready,

    input  logic [3:0]  SAXI_arid,
    input  logic [31:0] SAXI_araddr,
    input  logic [7:0]  SAXI_arlen,
    input  logic [2:0]  SAXI_arsize,
    input  logic [1:0]  SAXI_arburst,
    input  logic        SAXI_arvalid,
    output logic        SAXI_arready,

    output logic [3:0]  SAXI_rid,
    output logic [63:0] SAXI_rdata,
    output logic [1:0]  SAXI_rresp,
    output logic        SAXI_rlast,
    output logic        SAXI_rvalid,
    input  logic        SAXI_rready
);

    localparam int         IW         = MEM_LOG2 - 3;
    localparam int         WORDS      = 1 << IW;
    localparam logic [3:0] RD_WAIT_M1 = (RD_WAIT == 0) ? 4'd0 : 4'(RD_WAIT - 1);
    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

    function automatic logic f_wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

    function automatic logic [1:0] f_size_eff(input logic [2:0] size);
        return size[2] ? 2'd3 : size[1:0];
    endfunction

    // Reserved bursts and WRAP with an unsupported length both fall back to
    // INCR so the beats still land on distinct, predictable words.
    function automatic logic [1:0] f_burst_eff(input logic [1:0] burst, input logic [7:0] len);
        if (burst == 2'd3)
            return BURST_INCR;
        if (burst == BURST_WRAP && !f_wrap_len_ok(len))
            return BURST_INCR;
        return burst;
    endfunction

    function automatic logic f_addr_err(input logic [1:0] burst, input logic [2:0] size,
                                        input logic [7:0] len);
        return (burst == 2'd3) || size[2] || (burst == BURST_WRAP && !f_wrap_len_ok(len));
    endfunction

    // Next beat address; burst/size are already the effective values.
    function automatic logic [31:0] f_next_addr(input logic [31:0] addr, input logic [7:0] len,
                                                input logic [1:0] size, input logic [1:0] burst);
        logic [31:0] step;
        logic [31:0] mask;
        step = 32'd1 << size;
        mask = ((32'(len) + 32'd1) << size) - 32'd1;
        case (burst)
            BURST_FIXED: return addr;
            BURST_WRAP:  return (addr & ~mask) | ((addr + step) & mask);
            default:     return addr + step;
        endcase
    endfunction

    logic [63:0] r_mem [WORDS];

    // Output enable: handshakes only start one cycle after reset release.
    logic r_live;

    // Write channel state
    w_state_t    r_w_state, w_w_next;
    logic [3:0]  r_aw_id;
    logic [31:0] r_aw_addr;
    logic [7:0]  r_aw_len;
    logic [1:0]  r_aw_size;
    logic [1:0]  r_aw_burst;
    logic        r_aw_err;
    logic        r_w_err;
    logic [7:0]  r_w_cnt;
    logic [1:0]  r_bresp;

    logic        w_aw_hs, w_w_hs, w_b_hs, w_w_final, w_wlast_bad;
    logic [IW-1:0] w_wr_idx;

    // Read channel state
    r_state_t    r_r_state, w_r_next;
    logic [3:0]  r_ar_id;
    logic [31:0] r_ar_addr;
    logic [7:0]  r_ar_len;
    logic [1:0]  r_ar_size;
    logic [1:0]  r_ar_burst;
    logic [7:0]  r_r_cnt;
    logic [3:0]  r_r_wait;
    logic [1:0]  r_rresp;
    logic [63:0] r_rdata;

    logic        w_ar_hs, w_r_hs, w_r_final;
    logic        w_rd_load;
    logic [31:0] w_rd_addr;
    logic [31:0] w_ar_addr_next;

    assign w_aw_hs     = SAXI_awvalid & SAXI_awready;
    assign w_w_hs      = SAXI_wvalid & SAXI_wready;
    assign w_b_hs      = SAXI_bvalid & SAXI_bready;
    assign w_w_final   = (r_w_cnt == r_aw_len);
    assign w_wlast_bad = (SAXI_wlast != w_w_final);
    assign w_wr_idx    = r_aw_addr[MEM_LOG2-1:3];

    assign w_ar_hs        = SAXI_arvalid & SAXI_arready;
    assign w_r_hs         = SAXI_rvalid & SAXI_rready;
    assign w_r_final      = (r_r_cnt == r_ar_len);
    assign w_ar_addr_next = f_next_addr(r_ar_addr, r_ar_len, r_ar_size, r_ar_burst);

    assign SAXI_bid   = r_aw_id;
    assign SAXI_bresp = r_bresp;
    assign SAXI_rid   = r_ar_id;
    assign SAXI_rresp = r_rresp;
    assign SAXI_rdata = r_rdata;

    // Hold off ready outputs until the first clock after reset release
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_live <= 1'b0;
        else
            r_live <= 1'b1;
    end

    // Write FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_w_state <= W_IDLE;
        else
            r_w_state <= w_w_next;
    end

    // Write FSM next-state logic
    always_comb begin
        w_w_next = r_w_state;
        case (r_w_state)
            W_IDLE:  if (w_aw_hs) w_w_next = W_DATA;
            W_DATA:  if (w_w_hs && w_w_final) w_w_next = W_RESP;
            W_RESP:  if (w_b_hs) w_w_next = W_IDLE;
            default: w_w_next = W_IDLE;
        endcase
    end

    // Write FSM outputs
    always_comb begin
        SAXI_awready = r_live && (r_w_state == W_IDLE);
        SAXI_wready  = (r_w_state == W_DATA);
        SAXI_bvalid  = (r_w_state == W_RESP);
    end

    // Write address/counter/response bookkeeping
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_aw_id    <= '0;
            r_aw_addr  <= '0;
            r_aw_len   <= '0;
            r_aw_size  <= '0;
            r_aw_burst <= '0;
            r_aw_err   <= 1'b0;
            r_w_err    <= 1'b0;
            r_w_cnt    <= '0;
            r_bresp    <= RESP_OKAY;
        end else if (w_aw_hs) begin
            r_aw_id    <= SAXI_awid;
            r_aw_addr  <= SAXI_awaddr;
            r_aw_len   <= SAXI_awlen;
            r_aw_size  <= f_size_eff(SAXI_awsize);
            r_aw_burst <= f_burst_eff(SAXI_awburst, SAXI_awlen);
            r_aw_err   <= f_addr_err(SAXI_awburst, SAXI_awsize, SAXI_awlen);
            r_w_err    <= 1'b0;
            r_w_cnt    <= '0;
        end else if (w_w_hs) begin
            r_aw_addr <= f_next_addr(r_aw_addr, r_aw_len, r_aw_size, r_aw_burst);
            r_w_cnt   <= r_w_cnt + 8'd1;
            r_w_err   <= r_w_err | w_wlast_bad;
            if (w_w_final)
                r_bresp <= (r_aw_err || r_w_err || w_wlast_bad) ? RESP_SLVERR : RESP_OKAY;
        end
    end

    // SRAM byte-lane writes; contents survive reset
    always_ff @(posedge clock) begin
        if (w_w_hs) begin
            for (int b = 0; b < 8; b++) begin
                if (SAXI_wstrb[b])
                    r_mem[w_wr_idx][8*b +: 8] <= SAXI_wdata[8*b +: 8];
            end
        end
    end

    // Read FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_r_state <= R_IDLE;
        else
            r_r_state <= w_r_next;
    end

    // Read FSM next-state logic
    always_comb begin
        w_r_next = r_r_state;
        case (r_r_state)
            R_IDLE:  if (w_ar_hs) w_r_next = (RD_WAIT == 0) ? R_DATA : R_WAIT;
            R_WAIT:  if (r_r_wait == 4'd0) w_r_next = R_DATA;
            R_DATA:  if (w_r_hs && w_r_final) w_r_next = R_IDLE;
            default: w_r_next = R_IDLE;
        endcase
    end

    // Read FSM outputs
    always_comb begin
        SAXI_arready = r_live && (r_r_state == R_IDLE);
        SAXI_rvalid  = (r_r_state == R_DATA);
        SAXI_rlast   = (r_r_state == R_DATA) && w_r_final;
    end

    // Select which word (if any) is captured into the read data register this edge
    always_comb begin
        w_rd_load = 1'b0;
        w_rd_addr = '0;
        case (r_r_state)
            R_IDLE: begin
                if (w_ar_hs && RD_WAIT == 0) begin
                    w_rd_load = 1'b1;
                    w_rd_addr = SAXI_araddr;
                end
            end
            R_WAIT: begin
                if (r_r_wait == 4'd0) begin
                    w_rd_load = 1'b1;
                    w_rd_addr = r_ar_addr;
                end
            end
            R_DATA: begin
                if (w_r_hs && !w_r_final) begin
                    w_rd_load = 1'b1;
                    w_rd_addr = w_ar_addr_next;
                end
            end
            default: ;
        endcase
    end

    // Read address/counter/response bookkeeping and data capture; a write
    // to the same word on the capture edge is seen only by later loads
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ar_id    <= '0;
            r_ar_addr  <= '0;
            r_ar_len   <= '0;
            r_ar_size  <= '0;
            r_ar_burst <= '0;
            r_r_cnt    <= '0;
            r_r_wait   <= '0;
            r_rresp    <= RESP_OKAY;
            r_rdata    <= '0;
        end else begin
            if (w_ar_hs) begin
                r_ar_id    <= SAXI_arid;
                r_ar_addr  <= SAXI_araddr;
                r_ar_len   <= SAXI_arlen;
                r_ar_size  <= f_size_eff(SAXI_arsize);
                r_ar_burst <= f_burst_eff(SAXI_arburst, SAXI_arlen);
                r_rresp    <= f_addr_err(SAXI_arburst, SAXI_arsize, SAXI_arlen)
                              ? RESP_SLVERR : RESP_OKAY;
                r_r_cnt    <= '0;
                r_r_wait   <= RD_WAIT_M1;
            end else if (r_r_state == R_WAIT && r_r_wait != 4'd0) begin
                r_r_wait <= r_r_wait - 4'd1;
            end else if (w_r_hs && !w_r_final) begin
                r_ar_addr <= w_ar_addr_next;
                r_r_cnt   <= r_r_cnt + 8'd1;
            end
            if (w_rd_load)
                r_rdata <= r_mem[w_rd_addr[MEM_LOG2-1:3]];
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
`timescale 1ns/1ps
// Randomized and directed bench for axi_sram_slave against a byte-level
// memory model with closed-form burst address computation.
module tb_axi_sram_slave;

    localparam int MEM_LOG2 = 16;
    localparam int RD_WAIT  = 0;
    localparam int NWORDS   = 1 << (MEM_LOG2 - 3);

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  SAXI_awid = '0;
    logic [31:0] SAXI_awaddr = '0;
    logic [7:0]  SAXI_awlen = '0;
    logic [2:0]  SAXI_awsize = '0;
    logic [1:0]  SAXI_awburst = '0;
    logic        SAXI_awvalid = 1'b0;
    logic        SAXI_awready;
    logic [63:0] SAXI_wdata = '0;
    logic [7:0]  SAXI_wstrb = '0;
    logic        SAXI_wlast = 1'b0;
    logic        SAXI_wvalid = 1'b0;
    logic        SAXI_wready;
    logic [3:0]  SAXI_bid;
    logic [1:0]  SAXI_bresp;
    logic        SAXI_bvalid;
    logic        SAXI_bready = 1'b0;
    logic [3:0]  SAXI_arid = '0;
    logic [31:0] SAXI_araddr = '0;
    logic [7:0]  SAXI_arlen = '0;
    logic [2:0]  SAXI_arsize = '0;
    logic [1:0]  SAXI_arburst = '0;
    logic        SAXI_arvalid = 1'b0;
    logic        SAXI_arready;
    logic [3:0]  SAXI_rid;
    logic [63:0] SAXI_rdata;
    logic [1:0]  SAXI_rresp;
    logic        SAXI_rlast;
    logic        SAXI_rvalid;
    logic        SAXI_rready = 1'b0;

    always #5 clock = ~clock;

    axi_sram_slave #(.MEM_LOG2(MEM_LOG2), .RD_WAIT(RD_WAIT)) dut (
        .clock(clock), .reset(reset),
        .SAXI_awid(SAXI_awid), .SAXI_awaddr(SAXI_awaddr), .SAXI_awlen(SAXI_awlen),
        .SAXI_awsize(SAXI_awsize), .SAXI_awburst(SAXI_awburst),
        .SAXI_awvalid(SAXI_awvalid), .SAXI_awready(SAXI_awready),
        .SAXI_wdata(SAXI_wdata), .SAXI_wstrb(SAXI_wstrb), .SAXI_wlast(SAXI_wlast),
        .SAXI_wvalid(SAXI_wvalid), .SAXI_wready(SAXI_wready),
        .SAXI_bid(SAXI_bid), .SAXI_bresp(SAXI_bresp), .SAXI_bvalid(SAXI_bvalid),
        .SAXI_bready(SAXI_bready),
        .SAXI_arid(SAXI_arid), .SAXI_araddr(SAXI_araddr), .SAXI_arlen(SAXI_arlen),
        .SAXI_arsize(SAXI_arsize), .SAXI_arburst(SAXI_arburst),
        .SAXI_arvalid(SAXI_arvalid), .SAXI_arready(SAXI_arready),
        .SAXI_rid(SAXI_rid), .SAXI_rdata(SAXI_rdata), .SAXI_rresp(SAXI_rresp),
        .SAXI_rlast(SAXI_rlast), .SAXI_rvalid(SAXI_rvalid), .SAXI_rready(SAXI_rready)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] m_mem [NWORDS];
    logic [63:0] wd   [256];
    logic [7:0]  ws   [256];
    logic [63:0] rexp [256];
    time aw_time, ar_time;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // i-th beat address computed directly from the burst rules
    function automatic logic [31:0] beat_addr(input logic [31:0] start, input int len,
                                              input int size, input int burst, input int i);
        int sz;
        longint step, c, s, base;
        sz   = (size > 3) ? 3 : size;
        step = longint'(1) << sz;
        s    = longint'(start);
        if (burst == 0)
            return start;
        if (burst == 2 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
            c    = longint'(len + 1) * step;
            base = s - (s % c);
            return 32'(base + ((s - base + longint'(i) * step) % c));
        end
        return 32'(s + longint'(i) * step);
    endfunction

    function automatic logic [1:0] exp_resp(input int len, input int size, input int burst,
                                            input int bad);
        logic err;
        err = (burst == 3) || (size > 3) ||
              (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) || (bad >= 0);
        return err ? 2'b10 : 2'b00;
    endfunction

    task automatic aw_phase(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input int size, input int burst);
        int t;
        SAXI_awid = id; SAXI_awaddr = addr; SAXI_awlen = 8'(len);
        SAXI_awsize = 3'(size); SAXI_awburst = 2'(burst); SAXI_awvalid = 1'b1;
        t = 0;
        @(negedge clock);
        while (!SAXI_awready && t < 100) begin @(posedge clock); @(negedge clock); t++; end
        check("aw_handshake", 64'(SAXI_awready), 64'(1));
        @(posedge clock); aw_time = $time; #1;
        SAXI_awvalid = 1'b0;
    endtask

    task automatic ar_phase(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input int size, input int burst);
        int t;
        SAXI_arid = id; SAXI_araddr = addr; SAXI_arlen = 8'(len);
        SAXI_arsize = 3'(size); SAXI_arburst = 2'(burst); SAXI_arvalid = 1'b1;
        t = 0;
        @(negedge clock);
        while (!SAXI_arready && t < 100) begin @(posedge clock); @(negedge clock); t++; end
        check("ar_handshake", 64'(SAXI_arready), 64'(1));
        @(posedge clock); ar_time = $time; #1;
        SAXI_arvalid = 1'b0;
    endtask

    task automatic w_beats(input logic [31:0] addr, input int len, input int size,
                           input int burst, input int bad);
        int t;
        logic [31:0] a;
        logic [12:0] wi;
        for (int i = 0; i <= len; i++) begin
            SAXI_wdata = wd[i]; SAXI_wstrb = ws[i];
            SAXI_wlast = (i == len) ^ (i == bad); SAXI_wvalid = 1'b1;
            t = 0;
            @(negedge clock);
            while (!SAXI_wready && t < 100) begin @(posedge clock); @(negedge clock); t++; end
            check("w_handshake", 64'(SAXI_wready), 64'(1));
            a  = beat_addr(addr, len, size, burst, i);
            wi = a[15:3];
            for (int b = 0; b < 8; b++)
                if (ws[i][b]) m_mem[wi][8*b +: 8] = wd[i][8*b +: 8];
            @(posedge clock); #1;
        end
        SAXI_wvalid = 1'b0; SAXI_wlast = 1'b0;
    endtask

    task automatic b_phase(input logic [3:0] id, input logic [1:0] resp, input int hold);
        int t;
        SAXI_bready = 1'b0;
        for (int k = 0; k < hold; k++) begin
            @(negedge clock);
            check("b_hold_valid", 64'(SAXI_bvalid), 64'(1));
            check("b_hold_bid", 64'(SAXI_bid), 64'(id));
            check("b_hold_bresp", 64'(SAXI_bresp), 64'(resp));
            check("b_hold_awready", 64'(SAXI_awready), 64'(0));
            @(posedge clock); #1;
        end
        SAXI_bready = 1'b1;
        t = 0;
        @(negedge clock);
        while (!SAXI_bvalid && t < 100) begin @(posedge clock); @(negedge clock); t++; end
        check("b_valid", 64'(SAXI_bvalid), 64'(1));
        check("b_id", 64'(SAXI_bid), 64'(id));
        check("b_resp", 64'(SAXI_bresp), 64'(resp));
        check("awready_in_resp", 64'(SAXI_awready), 64'(0));
        @(posedge clock); #1;
        SAXI_bready = 1'b0;
        check("awready_after_b", 64'(SAXI_awready), 64'(1));
    endtask

    task automatic rd_expect(input logic [31:0] addr, input int len, input int size,
                             input int burst);
        logic [31:0] a;
        for (int i = 0; i <= len; i++) begin
            a = beat_addr(addr, len, size, burst, i);
            rexp[i] = m_mem[a[15:3]];
        end
    endtask

    // mode 0: rready always high, 1: toggling, 2: random
    task automatic r_beats(input logic [3:0] id, input int len, input logic [1:0] resp,
                           input int mode, input int stop);
        int got, cyc, lat, want;
        logic seen, stalled;
        logic [63:0] held;
        got = 0; cyc = 0; lat = 0; seen = 1'b0; stalled = 1'b0; held = '0;
        want = (stop < len + 1) ? stop : len + 1;
        while (got < want && cyc < 2000) begin
            SAXI_rready = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
            @(negedge clock);
            if (SAXI_rvalid) begin
                if (!seen) begin
                    check("r_first_latency", 64'(lat), 64'(RD_WAIT));
                    seen = 1'b1;
                end
                if (stalled)
                    check("r_stall_stable", SAXI_rdata, held);
                if (SAXI_rready) begin
                    check("r_data", SAXI_rdata, rexp[got]);
                    check("r_id", 64'(SAXI_rid), 64'(id));
                    check("r_resp", 64'(SAXI_rresp), 64'(resp));
                    check("r_last", 64'(SAXI_rlast), 64'(got == len));
                    got++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held = SAXI_rdata;
                end
            end else if (!seen) begin
                lat++;
            end
            @(posedge clock); #1;
            cyc++;
        end
        SAXI_rready = 1'b0;
        check("r_beat_count", 64'(got), 64'(want));
        if (want == len + 1)
            check("r_idle_after", 64'(SAXI_rvalid), 64'(0));
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input int size, input int burst, input int bad, input int hold);
        aw_phase(id, addr, len, size, burst);
        w_beats(addr, len, size, burst, bad);
        b_phase(id, exp_resp(len, size, burst, bad), hold);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input int size, input int burst, input int mode);
        rd_expect(addr, len, size, burst);
        ar_phase(id, addr, len, size, burst);
        r_beats(id, len, exp_resp(len, size, burst, -1), mode, 1000);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_handshake"}, 64'({SAXI_awready, SAXI_wready, SAXI_bvalid,
                                        SAXI_arready, SAXI_rvalid, SAXI_rlast}), 64'(0));
        check({tag, "_b"}, 64'({SAXI_bid, SAXI_bresp}), 64'(0));
        check({tag, "_r"}, 64'({SAXI_rid, SAXI_rresp}), 64'(0));
        check({tag, "_rdata"}, SAXI_rdata, 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] old;
        int len, size, burst, bad, mode, hold;
        logic [31:0] addr;
        logic [3:0] id;

        #12;
        check_all_zero("reset");
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;

        // W beats offered before any address phase are not taken
        SAXI_wvalid = 1'b1;
        repeat (3) begin
            @(negedge clock);
            check("wready_in_idle", 64'(SAXI_wready), 64'(0));
        end
        @(posedge clock); #1;
        SAXI_wvalid = 1'b0;

        // Prefill the working region 0x000..0x7FF
        for (int i = 0; i < 256; i++) begin
            wd[i] = {$urandom, $urandom};
            ws[i] = 8'hFF;
        end
        do_write(4'h1, 32'h0, 255, 3, 1, -1, 0);

        // Single write then read
        wd[0] = 64'h1122334455667788; ws[0] = 8'hFF;
        do_write(4'h5, 32'h100, 0, 3, 1, -1, 0);
        rd_expect(32'h100, 0, 3, 1);
        rexp[0] = 64'h1122334455667788;
        ar_phase(4'h9, 32'h100, 0, 3, 1);
        r_beats(4'h9, 0, 2'b00, 0, 1000);

        // INCR len 3 with partial strobe on beat 1, read with toggling rready
        old = m_mem[13'(32'h208 >> 3)];
        for (int i = 0; i < 4; i++) begin
            wd[i] = {$urandom, $urandom};
            ws[i] = 8'hFF;
        end
        ws[1] = 8'h0F;
        do_write(4'h2, 32'h200, 3, 3, 1, -1, 0);
        rd_expect(32'h200, 3, 3, 1);
        rexp[0] = wd[0]; rexp[1] = {old[63:32], wd[1][31:0]};
        rexp[2] = wd[2]; rexp[3] = wd[3];
        ar_phase(4'h3, 32'h200, 3, 3, 1);
        r_beats(4'h3, 3, 2'b00, 1, 1000);

        // WRAP len 3 at 0x118 visits 0x118, 0x100, 0x108, 0x110
        wd[0] = 64'hA0A0_0000_0000_0100; wd[1] = 64'hA1A1_0000_0000_0108;
        wd[2] = 64'hA2A2_0000_0000_0110; wd[3] = 64'hA3A3_0000_0000_0118;
        for (int i = 0; i < 4; i++) ws[i] = 8'hFF;
        do_write(4'h4, 32'h100, 3, 3, 1, -1, 0);
        ar_phase(4'h6, 32'h118, 3, 3, 2);
        rexp[0] = 64'hA3A3_0000_0000_0118; rexp[1] = 64'hA0A0_0000_0000_0100;
        rexp[2] = 64'hA1A1_0000_0000_0108; rexp[3] = 64'hA2A2_0000_0000_0110;
        r_beats(4'h6, 3, 2'b00, 0, 1000);
        // Illegal WRAP length answers SLVERR on every beat
        do_read(4'h7, 32'h100, 2, 3, 2, 0);

        // Long B stall, then wlast asserted early on a two-beat burst
        wd[0] = 64'hDEAD_BEEF_0000_0001; ws[0] = 8'hFF;
        do_write(4'hA, 32'h180, 0, 3, 1, -1, 10);
        wd[0] = 64'h0102030405060708; wd[1] = 64'h1112131415161718;
        ws[0] = 8'hFF; ws[1] = 8'hFF;
        do_write(4'hB, 32'h188, 1, 3, 1, 0, 2);
        do_read(4'hC, 32'h180, 2, 3, 1, 0);

        // Address decoded modulo memory size
        wd[0] = 64'hCAFE_F00D_1234_5678; ws[0] = 8'hFF;
        do_write(4'hD, 32'h1234_0108, 0, 3, 1, -1, 0);
        rd_expect(32'h108, 0, 3, 1);
        rexp[0] = 64'hCAFE_F00D_1234_5678;
        ar_phase(4'hE, 32'h108, 0, 3, 1);
        r_beats(4'hE, 0, 2'b00, 0, 1000);

        // AR and AW on the same cycle to the same word: old data returned
        rd_expect(32'h300, 0, 3, 1);
        wd[0] = 64'h5555_AAAA_5555_AAAA; ws[0] = 8'hFF;
        fork
            aw_phase(4'h1, 32'h300, 0, 3, 1);
            ar_phase(4'h2, 32'h300, 0, 3, 1);
        join
        check("aw_ar_same_cycle", 64'(aw_time), 64'(ar_time));
        fork
            w_beats(32'h300, 0, 3, 1, -1);
            r_beats(4'h2, 0, 2'b00, 0, 1000);
        join
        b_phase(4'h1, 2'b00, 0);
        do_read(4'h3, 32'h300, 0, 3, 1, 0);

        // Write beat and read capture on the same edge: the read sees old data
        wd[0] = 64'h0F0F_0F0F_F0F0_F0F0; ws[0] = 8'hFF;
        aw_phase(4'h4, 32'h308, 0, 3, 1);
        rd_expect(32'h308, 0, 3, 1);
        fork
            w_beats(32'h308, 0, 3, 1, -1);
            ar_phase(4'h5, 32'h308, 0, 3, 1);
        join
        r_beats(4'h5, 0, 2'b00, 0, 1000);
        b_phase(4'h4, 2'b00, 0);
        do_read(4'h6, 32'h308, 0, 3, 1, 0);

        // Reset in the middle of a len-7 read
        rd_expect(32'h400, 7, 3, 1);
        ar_phase(4'h8, 32'h400, 7, 3, 1);
        r_beats(4'h8, 7, 2'b00, 0, 3);
        reset = 1'b0;
        #2;
        check_all_zero("midreset");
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        do_read(4'h9, 32'h400, 7, 3, 1, 2);

        // Randomized traffic within the prefilled region
        for (int n = 0; n < 60; n++) begin
            len   = $urandom_range(0, 15);
            size  = ($urandom_range(0, 3) == 0) ? $urandom_range(4, 7) : $urandom_range(0, 3);
            burst = $urandom_range(0, 3);
            addr  = 32'($urandom_range(0, 'h6FF));
            id    = 4'($urandom_range(0, 15));
            mode  = $urandom_range(0, 2);
            hold  = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 0) begin
                bad = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len) : -1;
                for (int i = 0; i <= len; i++) begin
                    wd[i] = {$urandom, $urandom};
                    ws[i] = 8'($urandom_range(0, 255));
                end
                do_write(id, addr, len, size, burst, bad, hold);
            end else begin
                do_read(id, addr, len, size, burst, mode);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
